// File: rtl/sram_like_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_slave_pkg
// Brief    : Shared size codes and response-entry layout for the sram-like slave.
// Revision : 1.0
// ============================================================================
package sram_like_slave_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int CD_W         = 4;
  localparam int RESP_ENTRY_W = 1 + 1 + CD_W + 32;

  typedef struct packed {
    logic            wr;
    logic            captured;
    logic [CD_W-1:0] countdown;
    logic [31:0]     data;
  } resp_entry_t;

endpackage
`default_nettype wire

// File: rtl/sram_like_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_resp_fifo
// Brief    : In-order response queue with per-entry SRAM data capture and
//            release countdown.
// Revision : 1.0
// ============================================================================
module sram_like_resp_fifo
  import sram_like_slave_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DELAY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        push_wr,
  input  logic        capture,
  input  logic [31:0] capture_data,
  input  logic        pop,
  output logic        head_ready,
  output logic [31:0] head_data,
  output logic        full
);

  localparam int               PTR_W       = $clog2(DEPTH);
  localparam logic [PTR_W:0]   c_depth_cnt = (PTR_W+1)'(DEPTH);

  logic [RESP_ENTRY_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]        r_valid;
  logic [PTR_W-1:0]        r_head;
  logic [PTR_W-1:0]        r_tail;
  logic [PTR_W-1:0]        r_cap_ptr;
  logic [PTR_W:0]          r_count;

  resp_entry_t      w_cur [DEPTH];
  resp_entry_t      w_nxt [DEPTH];
  logic [DEPTH-1:0] w_nxt_valid;
  logic             w_capturing [DEPTH];
  resp_entry_t      w_head;
  logic             w_cap_head;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_cur[i]       = r_mem[i];
      w_nxt[i]       = w_cur[i];
      w_nxt_valid[i] = r_valid[i];
      w_capturing[i] = capture && (r_cap_ptr == PTR_W'(i));
      if (push && (r_tail == PTR_W'(i))) begin
        w_nxt[i]       = '{wr: push_wr, captured: 1'b0, countdown: CD_W'(DELAY), data: 32'd0};
        w_nxt_valid[i] = 1'b1;
      end else if (pop && (r_head == PTR_W'(i))) begin
        w_nxt_valid[i] = 1'b0;
      end else if (r_valid[i]) begin
        if (w_capturing[i]) begin
          w_nxt[i].captured = 1'b1;
          w_nxt[i].data     = w_cur[i].wr ? 32'd0 : capture_data;
        end
        // The capture cycle already counts as the first countdown cycle.
        if ((w_cur[i].captured || w_capturing[i]) && (w_cur[i].countdown != '0)) begin
          w_nxt[i].countdown = w_cur[i].countdown - 1'b1;
        end
      end
    end
  end

  // A head entry with no delay left may release in its own capture cycle.
  assign w_head     = r_mem[r_head];
  assign w_cap_head = capture && (r_cap_ptr == r_head);
  assign head_ready = r_valid[r_head] && (w_head.captured || w_cap_head)
                      && (w_head.countdown == '0);
  assign head_data  = w_cap_head ? (w_head.wr ? 32'd0 : capture_data) : w_head.data;
  assign full       = (r_count == c_depth_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head    <= '0;
      r_tail    <= '0;
      r_cap_ptr <= '0;
      r_count   <= '0;
      r_valid   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= w_nxt[i];
      end
      r_valid <= w_nxt_valid;
      if (push) begin
        r_tail    <= r_tail + 1'b1;
        r_cap_ptr <= r_tail;
      end
      if (pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/sram_like_slave.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_slave
// Brief    : sram-like bus responder backed by a single-cycle synchronous SRAM,
//            returning in-order responses after a fixed delay.
// Revision : 1.0
// ============================================================================
module sram_like_slave
  import sram_like_slave_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DELAY  = 2,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [3:0]        wstrb,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  logic        w_full;
  logic        w_handshake;
  logic        w_head_ready;
  logic [31:0] w_head_data;
  logic [1:0]  w_size_norm;
  logic        w_addr_hi_unused;
  logic        w_unused;

  logic        r_capture;
  logic        r_data_ok;
  logic [31:0] r_rdata;

  assign addr_ok     = req && !w_full;
  assign w_handshake = req && addr_ok;

  assign ram_en    = w_handshake;
  assign ram_wen   = (w_handshake && wr) ? wstrb : 4'b0000;
  assign ram_addr  = addr[ADDR_W+1:2];
  assign ram_wdata = wdata;

  // Size is informational only; the master already lane-aligns wstrb.
  assign w_size_norm = (size == 2'd3) ? SIZE_WORD : size;

  if (ADDR_W + 2 < 32) begin : g_addr_hi
    assign w_addr_hi_unused = ^addr[31:ADDR_W+2];
  end else begin : g_no_addr_hi
    assign w_addr_hi_unused = 1'b0;
  end

  assign w_unused = ^{w_size_norm == SIZE_BYTE, w_size_norm == SIZE_HALF,
                      addr[1:0], w_addr_hi_unused};

  sram_like_resp_fifo #(
    .DEPTH (DEPTH),
    .DELAY (DELAY)
  ) u_resp_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (w_handshake),
    .push_wr      (wr),
    .capture      (r_capture),
    .capture_data (ram_rdata),
    .pop          (w_head_ready),
    .head_ready   (w_head_ready),
    .head_data    (w_head_data),
    .full         (w_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_capture <= 1'b0;
      r_data_ok <= 1'b0;
      r_rdata   <= 32'd0;
    end else begin
      r_capture <= w_handshake;
      r_data_ok <= w_head_ready;
      if (w_head_ready) begin
        r_rdata <= w_head_data;
      end
    end
  end

  assign data_ok = r_data_ok;
  assign rdata   = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_like_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_like_slave
// Brief    : Directed bench for sram_like_slave in three DEPTH/DELAY builds.
// Revision : 1.0
// ============================================================================
module tb_sram_like_slave;

  localparam int N = 3;

  function automatic int depth_of(input int k);
    return (k == 1) ? 2 : 4;
  endfunction

  function automatic int delay_of(input int k);
    return (k == 1) ? 4 : ((k == 2) ? 0 : 2);
  endfunction

  function automatic logic [31:0] init_word(input int w);
    return (w == 16) ? 32'h12345678 : (32'hC0DE0000 | 32'(w));
  endfunction

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        req       [N];
  logic        wr        [N];
  logic [1:0]  size      [N];
  logic [3:0]  wstrb     [N];
  logic [31:0] addr      [N];
  logic [31:0] wdata     [N];
  logic        addr_ok   [N];
  logic        data_ok   [N];
  logic [31:0] rdata     [N];
  logic        ram_en    [N];
  logic [3:0]  ram_wen   [N];
  logic [15:0] ram_addr  [N];
  logic [31:0] ram_wdata [N];

  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;

  int          due_q   [N][$];
  logic [31:0] dat_q   [N][$];
  logic [31:0] ref_mem [N][256];
  logic [31:0] last_rd [N];
  int          exp_off [4] = '{0, 1, 6, 7};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < N; k++) begin : g_dut
    logic [31:0] mem [256];
    logic [31:0] ram_rdata;

    initial for (int w = 0; w < 256; w++) mem[w] = init_word(w);

    always @(posedge clk) begin
      if (ram_en[k]) begin
        ram_rdata <= mem[ram_addr[k][7:0]];
        for (int b = 0; b < 4; b++)
          if (ram_wen[k][b]) mem[ram_addr[k][7:0]][8*b +: 8] = ram_wdata[k][8*b +: 8];
      end
    end

    sram_like_slave #(
      .DEPTH  (depth_of(k)),
      .DELAY  (delay_of(k)),
      .ADDR_W (16)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req[k]),
      .wr        (wr[k]),
      .size      (size[k]),
      .wstrb     (wstrb[k]),
      .addr      (addr[k]),
      .wdata     (wdata[k]),
      .addr_ok   (addr_ok[k]),
      .data_ok   (data_ok[k]),
      .rdata     (rdata[k]),
      .ram_en    (ram_en[k]),
      .ram_wen   (ram_wen[k]),
      .ram_addr  (ram_addr[k]),
      .ram_wdata (ram_wdata[k]),
      .ram_rdata (ram_rdata)
    );
  end

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d cyc=%0d actual=%h required=%h", name, k, cyc, act, exp);
  endtask

  // Model: a response is due exactly 2+DELAY cycles after acceptance; a slot
  // stays occupied until the cycle its response appears.
  always @(negedge clk) begin : p_compare
    int          outst;
    logic        exp_ok;
    logic        exp_dok;
    logic [7:0]  idx;
    for (int k = 0; k < N; k++) begin
      if (reset) begin
        due_q[k].delete();
        dat_q[k].delete();
        last_rd[k] = 32'd0;
      end
      outst = 0;
      for (int j = 0; j < due_q[k].size(); j++) if (due_q[k][j] > cyc) outst++;
      exp_ok  = req[k] && (outst < depth_of(k));
      exp_dok = (due_q[k].size() != 0) && (due_q[k][0] == cyc);
      if (exp_dok) begin
        last_rd[k] = dat_q[k][0];
        void'(due_q[k].pop_front());
        void'(dat_q[k].pop_front());
      end
      chk("addr_ok", k, 32'(addr_ok[k]), 32'(exp_ok));
      chk("data_ok", k, 32'(data_ok[k]), 32'(exp_dok));
      chk("rdata", k, rdata[k], last_rd[k]);
      if (exp_ok) begin
        idx = addr[k][9:2];
        chk("ram_en", k, 32'(ram_en[k]), 32'd1);
        chk("ram_wen", k, 32'(ram_wen[k]), wr[k] ? 32'(wstrb[k]) : 32'd0);
        chk("ram_addr", k, 32'(ram_addr[k]), 32'(addr[k][17:2]));
        chk("ram_wdata", k, ram_wdata[k], wdata[k]);
        due_q[k].push_back(cyc + 2 + delay_of(k));
        dat_q[k].push_back(wr[k] ? 32'd0 : ref_mem[k][idx]);
        if (wr[k])
          for (int b = 0; b < 4; b++)
            if (wstrb[k][b]) ref_mem[k][idx][8*b +: 8] = wdata[k][8*b +: 8];
      end else begin
        chk("ram_en_idle", k, 32'(ram_en[k]), 32'd0);
        chk("ram_wen_idle", k, 32'(ram_wen[k]), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg(input int c);
    @(negedge clk);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drive(input int k, input logic w, input logic [1:0] sz,
                       input logic [3:0] st, input logic [31:0] a, input logic [31:0] d);
    req[k] = 1'b1; wr[k] = w; size[k] = sz; wstrb[k] = st; addr[k] = a; wdata[k] = d;
  endtask

  initial begin
    int t;
    int n_acc;
    int guard;
    int acc_cyc [4];
    for (int k = 0; k < N; k++) begin
      req[k] = 1'b0; wr[k] = 1'b0; size[k] = 2'd0; wstrb[k] = 4'd0;
      addr[k] = 32'd0; wdata[k] = 32'd0; last_rd[k] = 32'd0;
      for (int w = 0; w < 256; w++) ref_mem[k][w] = init_word(w);
    end
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();

    // Single read of preloaded word 0x10.
    t = cyc;
    drive(0, 1'b0, 2'd2, 4'b0000, 32'h40, 32'd0);
    at_neg(t);
    chk("s1_addr_ok", 0, 32'(addr_ok[0]), 32'd1);
    chk("s1_ram_addr", 0, 32'(ram_addr[0]), 32'h10);
    step(); req[0] = 1'b0;
    at_neg(t + 3); chk("s1_early", 0, 32'(data_ok[0]), 32'd0);
    at_neg(t + 4); chk("s1_data_ok", 0, 32'(data_ok[0]), 32'd1);
    chk("s1_rdata", 0, rdata[0], 32'h12345678);
    at_neg(t + 5); chk("s1_pulse", 0, 32'(data_ok[0]), 32'd0);
    step();

    // Half-word write followed immediately by a read of the same word.
    t = cyc;
    drive(0, 1'b1, 2'd1, 4'b0011, 32'h40, 32'h0000BEEF);
    step();
    drive(0, 1'b0, 2'd2, 4'b0000, 32'h40, 32'd0);
    step(); req[0] = 1'b0;
    at_neg(t + 4); chk("s3_wr_ok", 0, 32'(data_ok[0]), 32'd1);
    chk("s3_wr_rdata", 0, rdata[0], 32'd0);
    at_neg(t + 5); chk("s3_rd_rdata", 0, rdata[0], 32'h1234BEEF);
    step();

    // Byte write to the top lane, then read back.
    t = cyc;
    drive(0, 1'b1, 2'd0, 4'b1000, 32'h43, 32'hAA000000);
    at_neg(t);
    chk("s4_ram_wen", 0, 32'(ram_wen[0]), 32'h8);
    chk("s4_ram_addr", 0, 32'(ram_addr[0]), 32'h10);
    step();
    drive(0, 1'b0, 2'd2, 4'b0000, 32'h40, 32'd0);
    step(); req[0] = 1'b0;
    at_neg(t + 5); chk("s4_rdata", 0, rdata[0], 32'hAA34BEEF);
    step();

    // DEPTH=2 backpressure with req held high.
    t = cyc; n_acc = 0; guard = 0;
    while (n_acc < 4 && guard < 40) begin
      drive(1, 1'b0, 2'd2, 4'b0000, 32'(n_acc * 4), 32'd0);
      @(negedge clk);
      if (addr_ok[1]) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      step();
      guard++;
    end
    req[1] = 1'b0;
    chk("s2_accepts", 1, 32'(n_acc), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < n_acc) chk("s2_accept_cycle", 1, 32'(acc_cyc[i] - t), 32'(exp_off[i]));
    at_neg(t + 13); chk("s2_last_ok", 1, 32'(data_ok[1]), 32'd1);
    chk("s2_last_rdata", 1, rdata[1], 32'hC0DE0003);
    step();

    // DELAY=0 streaming reads.
    t = cyc;
    drive(2, 1'b0, 2'd2, 4'b0000, 32'h0, 32'd0);
    step();
    drive(2, 1'b0, 2'd2, 4'b0000, 32'h4, 32'd0);
    step();
    drive(2, 1'b0, 2'd2, 4'b0000, 32'h8, 32'd0);
    at_neg(t + 2); chk("s6_rd0", 2, rdata[2], 32'hC0DE0000);
    chk("s6_ok0", 2, 32'(data_ok[2]), 32'd1);
    step(); req[2] = 1'b0;
    at_neg(t + 3); chk("s6_rd1", 2, rdata[2], 32'hC0DE0001);
    at_neg(t + 4); chk("s6_rd2", 2, rdata[2], 32'hC0DE0002);
    step();

    // Asynchronous reset with three reads outstanding.
    t = cyc;
    drive(0, 1'b0, 2'd2, 4'b0000, 32'h0, 32'd0);
    step();
    drive(0, 1'b0, 2'd2, 4'b0000, 32'h4, 32'd0);
    step();
    drive(0, 1'b0, 2'd2, 4'b0000, 32'h8, 32'd0);
    step(); req[0] = 1'b0;
    @(posedge clk); #2;
    chk("s5_pre_ok", 0, 32'(data_ok[0]), 32'd1);
    reset = 1'b1;
    #1;
    chk("s5_rst_ok", 0, 32'(data_ok[0]), 32'd0);
    chk("s5_rst_rdata", 0, rdata[0], 32'd0);
    step(); step();
    reset = 1'b0;
    repeat (8) step();
    t = cyc;
    drive(0, 1'b0, 2'd2, 4'b0000, 32'h40, 32'd0);
    at_neg(t); chk("s5_post_addr_ok", 0, 32'(addr_ok[0]), 32'd1);
    step(); req[0] = 1'b0;

    repeat (10) step();
    for (int k = 0; k < N; k++) chk("drained", k, 32'(due_q[k].size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/sram_like_slave.md
Name: sram_like_slave

Overview:
- Responder end of the sram-like bus that the CPU core drives on its instruction and data ports (req/wr/size/wstrb/addr/wdata out; addr_ok/data_ok/rdata in).
- Accepts requests, performs each access on a single-cycle synchronous SRAM, and returns data_ok/rdata strictly in order after a fixed, configurable delay.
- Used as the memory side of the core in simulation and FPGA builds; one instance per core port (inst, data).

Parameters:
- DEPTH, 4, maximum outstanding (accepted, not yet answered) requests; power of two, >=2
- DELAY, 2, extra cycles between SRAM read-data return and data_ok; 0..15
- ADDR_W, 16, SRAM word-address width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req  in  1  request valid
- wr  in  1  1=write, 0=read
- size  in  2  0=byte, 1=half, 2=word; 3 treated as word
- wstrb  in  4  byte write strobes, already lane-aligned by the master
- addr  in  32  byte address
- wdata  in  32  write data, lane-aligned
- addr_ok  out  1  request accepted this cycle
- data_ok  out  1  one response returned this cycle
- rdata  out  32  read data, valid with data_ok
- ram_en  out  1  SRAM access enable
- ram_wen  out  4  SRAM byte write enables
- ram_addr  out  ADDR_W  SRAM word address = addr[ADDR_W+1:2]
- ram_wdata  out  32  equals wdata
- ram_rdata  in  32  SRAM read data, valid the cycle after ram_en

Behaviour:
- Reset (async, active-high): outstanding count, FIFO pointers and all countdowns cleared; data_ok=0; rdata=0. Reset mid-operation drops all outstanding responses; no data_ok is produced for them.
- addr_ok = req && (count < DEPTH), combinational. A pop in the same cycle does not free a slot for a push.
- Handshake = req && addr_ok. In the handshake cycle:
  - ram_en=1.
  - ram_wen = wr ? wstrb : 4'b0000.
  - ram_addr and ram_wdata are driven combinationally from the request.
  - Outside handshakes ram_en=0 and ram_wen=0.
- addr[1:0] are ignored for the SRAM address. There is no alignment check; size is recorded but not used for masking (the master supplies wstrb).
- Push: on handshake, allocate a tail entry with the wr flag and countdown=DELAY.
  - Next cycle, a read entry captures ram_rdata into its data field.
  - A write entry stores 0.
- Countdown: each valid entry whose data is captured decrements its counter by 1 per cycle until 0.
- Pop: when the head entry is captured and its countdown is 0, register data_ok=1 and rdata=head data for exactly one cycle, then advance head.
  - At most one pop per cycle.
  - No backpressure on data_ok; the master must accept.
- Latency: handshake in cycle T gives data_ok in cycle T+2+DELAY.
  - Back-to-back accepted requests produce back-to-back data_ok, one per cycle.
- Ordering: responses are strictly in acceptance order. Reads and writes share the same FIFO, so a write-then-read to the same address returns the new data (SRAM is written in T, read in T+1 or later).
- count increments on push and decrements on pop; both in the same cycle leave it unchanged. Pointers wrap modulo DEPTH.
- When data_ok=0, rdata holds its last value.

Decomposition:
- Shared package/header holds:
  - SIZE_BYTE=2'd0, SIZE_HALF=2'd1, SIZE_WORD=2'd2
  - response entry width macro: 1 wr + 1 captured + 4 countdown + 32 data
- One sub-module: sram_like_resp_fifo holds the DEPTH-entry storage, pointers, count, and per-entry countdowns; it exposes push, capture, head_ready and pop.
- The top level handles the handshake, SRAM drive and output registers.

Test Plan:
- DELAY=2, SRAM preloaded word 0x10 = 0x12345678; read addr=0x40 in cycle 5 → addr_ok=1 in cycle 5, ram_addr=0x10, data_ok=1 only in cycle 9 with rdata=0x12345678.
- DEPTH=2, DELAY=4, req held high for 4 reads → addr_ok high for the first 2 cycles, low until the first data_ok, then one accept per pop; 4 data_ok pulses in order with the matching data.
- Write addr=0x40 wstrb=4'b0011 wdata=0x0000BEEF over 0x12345678, then an immediate read of 0x40 → write data_ok with rdata=0, then read rdata=0x1234BEEF.
- Byte write size=0, addr=0x43, wstrb=4'b1000, wdata=0xAA000000 → ram_wen=4'b1000, ram_addr=0x10; a later read returns 0xAA34BEEF.
- Reset asserted asynchronously with 3 requests outstanding → data_ok=0 immediately; none of the 3 responses appears after release; addr_ok=1 on the next req.
- DELAY=0, continuous reads to 0x0,0x4,0x8 → data_ok in cycles T+2, T+3, T+4 with consecutive word data.
